// File: rtl/steer_en_sm_if.sv
// ---------------------------------------------------------------------------
// steer_en_sm_if
//   Bundles the load-cell inputs and the rider/steer outputs of steer_en_sm.
//   master: the producer of load-cell readings / consumer of results (bench,
//           upstream sampler).
//   slave : the steer_en_sm block itself.
//   Signals:
//     lft_ld, rght_ld  12-bit unsigned load-cell readings
//     ld_cell_diff     12-bit signed, saturated lft_ld - rght_ld (registered)
//     rider_off        1 = no rider present
//     en_steer         1 = steering enabled
// ---------------------------------------------------------------------------
interface steer_en_sm_if;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic [11:0] ld_cell_diff;
    logic        rider_off;
    logic        en_steer;

    modport master (
        output lft_ld, rght_ld,
        input  ld_cell_diff, rider_off, en_steer
    );

    modport slave (
        input  lft_ld, rght_ld,
        output ld_cell_diff, rider_off, en_steer
    );
endinterface

// File: rtl/steer_en_sm.sv
// ---------------------------------------------------------------------------
// steer_en_sm
//   Rider-presence and steering-enable stage ahead of the balance controller.
//   Decides whether a rider is on the platform (with hysteresis on total
//   weight), and enables steering only after the rider has stood balanced
//   for 2^N clocks (N = 15 with fast_sim, else 26).
//   Ports:
//     clk   in  system clock, rising edge
//     rst   in  synchronous active-high reset
//     bus   steer_en_sm_if.slave
//             lft_ld/rght_ld in, ld_cell_diff/rider_off/en_steer out
//   Parameters:
//     fast_sim      1: 15-bit stability timer, 0: 26-bit
//     MIN_RIDER_WT  nominal rider-present threshold on lft_ld + rght_ld
//     WT_HYST       hysteresis half-band around MIN_RIDER_WT
// ---------------------------------------------------------------------------
module steer_en_sm #(
    parameter bit          fast_sim     = 1'b0,
    parameter logic [11:0] MIN_RIDER_WT = 12'h200,
    parameter logic [11:0] WT_HYST      = 12'h040
) (
    input logic          clk,
    input logic          rst,
    steer_en_sm_if.slave bus
);

    localparam int TW = fast_sim ? 15 : 26;

    localparam logic [12:0]   ON_THR    = {1'b0, MIN_RIDER_WT} + {1'b0, WT_HYST};
    localparam logic [12:0]   OFF_THR   = {1'b0, MIN_RIDER_WT} - {1'b0, WT_HYST};
    localparam logic [TW-1:0] TIMER_ONE = {{(TW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT     = 2'd1,
        STEER_EN = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [11:0]   diff_q,  diff_d;

    // ------------------------------------------------------------------
    // Combinational arithmetic on the current load-cell readings
    // ------------------------------------------------------------------
    logic [12:0] sum;
    logic [12:0] diff;       // two's complement, bit 12 is the sign
    logic [12:0] abs_diff;
    logic [12:0] sum_q4;     // sum / 4
    logic [12:0] sum_15_16;  // sum - sum/16
    logic        on, off, balanced, lost;

    always_comb begin
        sum       = {1'b0, bus.lft_ld} + {1'b0, bus.rght_ld};
        diff      = {1'b0, bus.lft_ld} - {1'b0, bus.rght_ld};
        // |diff| peaks at 4095, so it always fits in 13 unsigned bits.
        abs_diff  = diff[12] ? (~diff + 13'd1) : diff;
        sum_q4    = sum >> 2;
        sum_15_16 = sum - (sum >> 4);

        on        = (sum > ON_THR);
        off       = (sum < OFF_THR);
        balanced  = (abs_diff < sum_q4);
        lost      = (abs_diff > sum_15_16);

        // Saturate to 12-bit signed: bits 12 and 11 disagree only when
        // the value lies outside [-2048, 2047].
        if (!diff[12] && diff[11]) begin
            diff_d = 12'h7FF;
        end else if (diff[12] && !diff[11]) begin
            diff_d = 12'h800;
        end else begin
            diff_d = diff[11:0];
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. off is always tested first so a rider stepping
    // off wins over any balance/lost condition on the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        unique case (state_q)
            IDLE: begin
                if (on) begin
                    state_d = WAIT;
                    timer_d = '0;
                end
            end
            WAIT: begin
                if (off) begin
                    state_d = IDLE;
                end else if (!balanced) begin
                    timer_d = '0;
                end else if (&timer_q) begin
                    // Entry at timer=0 plus 2^N-1 increments plus this
                    // edge gives exactly 2^N edges to STEER_EN.
                    state_d = STEER_EN;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            STEER_EN: begin
                if (off) begin
                    state_d = IDLE;
                end else if (lost) begin
                    state_d = WAIT;
                    timer_d = '0;
                end
            end
            default: begin
                // Unreachable encoding: recover to a safe state.
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            diff_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            diff_q  <= diff_d;
        end
    end

    // Outputs decode straight from the state register, so they are
    // glitch-free and mutually exclusive.
    assign bus.rider_off    = (state_q == IDLE);
    assign bus.en_steer     = (state_q == STEER_EN);
    assign bus.ld_cell_diff = diff_q;

endmodule

// File: tb/tb_steer_en_sm.sv
// ---------------------------------------------------------------------------
// tb_steer_en_sm
//   Scoreboard bench for steer_en_sm (fast_sim=1). The stimulus process
//   drives inputs just after a falling edge and queues the values the
//   outputs must hold after the following rising edge; the monitor pops
//   and compares on each falling edge.
// ---------------------------------------------------------------------------
module tb_steer_en_sm;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    steer_en_sm_if bus ();

    steer_en_sm #(.fast_sim(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       nm;
        int          tag;
        bit          ro;
        bit          es;
        logic [11:0] d;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t me;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic drive(input logic [11:0] l, input logic [11:0] r, input logic rs);
        @(negedge clk);
        bus.lft_ld  = l;
        bus.rght_ld = r;
        rst         = rs;
    endtask

    task automatic expect_o(input string nm, input bit ro, input bit es, input logic [11:0] d);
        exp_t e;
        e.nm  = nm;
        e.tag = cyc + 1;
        e.ro  = ro;
        e.es  = es;
        e.d   = d;
        q.push_back(e);
    endtask

    // Monitor
    always @(negedge clk) begin
        checks++;
        if (bus.rider_off && bus.en_steer) begin
            errors++;
            $display("FAIL excl at cycle %0d: rider_off=1 and en_steer=1 together", cyc);
        end
        while (q.size() > 0 && q[0].tag <= cyc) begin
            me = q.pop_front();
            if (me.tag != cyc) begin
                checks++;
                errors++;
                $display("FAIL %s not compared on cycle %0d (now %0d)", me.nm, me.tag, cyc);
            end else begin
                checks++;
                if (bus.rider_off !== me.ro) begin
                    errors++;
                    $display("FAIL %s rider_off got %b want %b", me.nm, bus.rider_off, me.ro);
                end
                checks++;
                if (bus.en_steer !== me.es) begin
                    errors++;
                    $display("FAIL %s en_steer got %b want %b", me.nm, bus.en_steer, me.es);
                end
                checks++;
                if (bus.ld_cell_diff !== me.d) begin
                    errors++;
                    $display("FAIL %s ld_cell_diff got %h want %h", me.nm, bus.ld_cell_diff, me.d);
                end
            end
        end
    end

    initial begin
        bus.lft_ld  = 12'hFFF;
        bus.rght_ld = 12'h000;

        // Reset with heavy, unbalanced inputs present
        drive(12'hFFF, 12'h000, 1'b1);
        drive(12'hFFF, 12'h000, 1'b1);
        expect_o("reset", 1'b1, 1'b0, 12'h000);

        // Phase A: enter WAIT, disturb balance at timer=20000, then count out
        drive(12'h300, 12'h300, 1'b0);
        expect_o("wait_entry_a", 1'b0, 1'b0, 12'h000);
        repeat (20000) drive(12'h300, 12'h300, 1'b0);
        drive(12'h500, 12'h100, 1'b0);
        expect_o("unbalanced", 1'b0, 1'b0, 12'h400);
        for (int k = 1; k <= 32768; k++) begin
            drive(12'h300, 12'h300, 1'b0);
            if (k == 32767) expect_o("pre_en_a", 1'b0, 1'b0, 12'h000);
            if (k == 32768) expect_o("en_a", 1'b0, 1'b1, 12'h000);
        end

        // Sum 0x200 sits inside the hysteresis band: STEER_EN holds
        drive(12'h100, 12'h100, 1'b0);
        expect_o("band_steer", 1'b0, 1'b1, 12'h000);

        // Reset while in STEER_EN, with inputs that would otherwise matter
        drive(12'hFFF, 12'h000, 1'b1);
        expect_o("rst_steer", 1'b1, 1'b0, 12'h000);

        // Phase B: exact 2^15 from WAIT entry
        drive(12'h300, 12'h300, 1'b0);
        expect_o("wait_entry_b", 1'b0, 1'b0, 12'h000);
        for (int k = 1; k <= 32768; k++) begin
            drive(12'h300, 12'h300, 1'b0);
            if (k == 32767) expect_o("pre_en_b", 1'b0, 1'b0, 12'h000);
            if (k == 32768) expect_o("en_b", 1'b0, 1'b1, 12'h000);
        end

        // Lost balance: diff 0x5E0 > 15/16 of 0x600 = 0x5A0
        drive(12'h5F0, 12'h010, 1'b0);
        expect_o("lost", 1'b0, 1'b0, 12'h5E0);

        // Hysteresis
        drive(12'h100, 12'h100, 1'b0);
        expect_o("band_wait", 1'b0, 1'b0, 12'h000);
        drive(12'h0C0, 12'h0C0, 1'b0);
        expect_o("off", 1'b1, 1'b0, 12'h000);
        drive(12'h100, 12'h100, 1'b0);
        expect_o("band_idle", 1'b1, 1'b0, 12'h000);
        drive(12'h130, 12'h130, 1'b0);
        expect_o("on", 1'b0, 1'b0, 12'h000);

        // Saturation and its edges (unbalanced, so state stays WAIT)
        drive(12'hFFF, 12'h000, 1'b0);
        expect_o("sat_pos", 1'b0, 1'b0, 12'h7FF);
        drive(12'h000, 12'hFFF, 1'b0);
        expect_o("sat_neg", 1'b0, 1'b0, 12'h800);
        drive(12'h7FF, 12'h000, 1'b0);
        expect_o("edge_pos", 1'b0, 1'b0, 12'h7FF);
        drive(12'h000, 12'h800, 1'b0);
        expect_o("edge_neg", 1'b0, 1'b0, 12'h800);
        drive(12'h000, 12'h801, 1'b0);
        expect_o("sat_neg1", 1'b0, 1'b0, 12'h800);

        // off wins over !balanced
        drive(12'h000, 12'h100, 1'b0);
        expect_o("off_prio", 1'b1, 1'b0, 12'hF00);

        // Exact on threshold: 0x240 holds, 0x241 enters WAIT
        drive(12'h120, 12'h120, 1'b0);
        expect_o("on_thr_eq", 1'b1, 1'b0, 12'h000);
        drive(12'h120, 12'h121, 1'b0);
        expect_o("on_thr_p1", 1'b0, 1'b0, 12'hFFF);

        // Exact off threshold: 0x1C0 holds, 0x1BF leaves
        drive(12'h0E0, 12'h0E0, 1'b0);
        expect_o("off_thr_eq", 1'b0, 1'b0, 12'h000);
        drive(12'h0E0, 12'h0DF, 1'b0);
        expect_o("off_thr_m1", 1'b1, 1'b0, 12'h001);

        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain %0d expectations left, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
